// File: rtl/pc_sequencer.sv
// Program-counter sequencer with stall/increment/jump/relative modes and an optional return-address stack.
// Define PC_SEQUENCER_RAS_EN to build in the return-address stack; without it, calls and returns degrade to plain jumps and increments.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 64,
  parameter int unsigned      STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
  parameter int unsigned      RAS_DEPTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       PS,
  input  logic [WIDTH-1:0] PC_IN,
  output logic [WIDTH-1:0] PC_OUT,
  output logic [WIDTH-1:0] PC4,
  output logic             ras_full,
  output logic             ras_empty,
  output logic             ras_err
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [2:0] {
    PS_HOLD  = 3'b000,
    PS_INC   = 3'b001,
    PS_JMP   = 3'b010,
    PS_REL   = 3'b011,
    PS_CALL  = 3'b100,
    PS_RET   = 3'b101,
    PS_RCALL = 3'b110,
    PS_RSVD  = 3'b111
  } ps_e;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_depth_check
    $error("RAS_DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_rel;
  logic [WIDTH-1:0] pc_next;

  assign pc_inc = pc + STEP_W;
  assign pc_rel = pc + PC_IN;
  assign PC_OUT = pc;
  assign PC4    = pc_inc;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int unsigned     PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             err;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             err_set;

  assign rd_ptr    = wr_ptr - PTR_ONE;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == {(PTR_W + 1){1'b0}});
  assign ras_full  = full;
  assign ras_empty = empty;
  assign ras_err   = err;

  // Next-PC selection and stack push/pop decisions for this edge.
  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (ps_e'(PS))
      PS_HOLD: pc_next = pc;
      PS_INC:  pc_next = pc_inc;
      PS_JMP:  pc_next = PC_IN;
      PS_REL:  pc_next = pc_rel;
      PS_CALL: begin
        push    = 1'b1;
        pc_next = PC_IN;
        err_set = full;
      end
      PS_RET: begin
        if (empty) begin
          pc_next = pc_inc;
          err_set = 1'b1;
        end else begin
          pop     = 1'b1;
          pc_next = ras_mem[rd_ptr];
        end
      end
      PS_RCALL: begin
        push    = 1'b1;
        pc_next = pc_rel;
        err_set = full;
      end
      PS_RSVD: pc_next = pc;
      default: pc_next = pc;
    endcase
  end

  // Stack storage has no reset: an entry is always written before it can be popped.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[wr_ptr] <= pc_inc;
    end
  end

  // PC, stack pointer, saturating occupancy and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_VECTOR;
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {(PTR_W + 1){1'b0}};
      err    <= 1'b0;
    end else begin
      pc <= pc_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (!full) begin
          count <= count + CNT_ONE;
        end
      end else if (pop) begin
        wr_ptr <= rd_ptr;
        count  <= count - CNT_ONE;
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_err   = 1'b0;

  // Without a stack, calls act as jumps and returns as sequential advance.
  always_comb begin
    pc_next = pc;
    case (ps_e'(PS))
      PS_HOLD:  pc_next = pc;
      PS_INC:   pc_next = pc_inc;
      PS_JMP:   pc_next = PC_IN;
      PS_REL:   pc_next = pc_rel;
      PS_CALL:  pc_next = PC_IN;
      PS_RET:   pc_next = pc_inc;
      PS_RCALL: pc_next = pc_rel;
      PS_RSVD:  pc_next = pc;
      default:  pc_next = pc;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else begin
      pc <= pc_next;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; expectations follow the stack-enabled or stack-less build via PC_SEQUENCER_RAS_EN.
module tb_pc_sequencer;

  localparam int         W  = 16;
  localparam logic [W-1:0] RV = 16'h0008;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam logic [2:0] F_IDLE = 3'b010;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   PS;
  logic [W-1:0] PC_IN;
  logic [W-1:0] PC_OUT;
  logic [W-1:0] PC4;
  logic         ras_full;
  logic         ras_empty;
  logic         ras_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]   ps;
    logic [W-1:0] pc_in;
    logic [W-1:0] pc;
    logic [2:0]   flags;
    string        name;
  } vec_t;

  typedef struct {
    logic [W-1:0] pc;
    logic [2:0]   flags;
    string        name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  pc_sequencer #(
    .WIDTH(W), .STEP(1), .RESET_VECTOR(RV), .RAS_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .PS(PS), .PC_IN(PC_IN), .PC_OUT(PC_OUT), .PC4(PC4),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name, input logic [W-1:0] pc);
    check({name, ".pc"}, PC_OUT, pc);
    check({name, ".pc4"}, PC4, pc + 16'd1);
    check({name, ".flags"}, {13'd0, ras_full, ras_empty, ras_err}, {13'd0, F_IDLE});
  endtask

  // Expectation is queued now and compared once the next edge has produced it.
  task automatic expect_next(input logic [W-1:0] pc, input logic [2:0] flags, input string name);
    exp_t e;
    e.pc = pc; e.flags = flags; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got empty scoreboard, expected one entry", name);
    end else begin
      e = sb.pop_front();
      check({e.name, ".pc"}, PC_OUT, e.pc);
      check({e.name, ".pc4"}, PC4, e.pc + 16'd1);
      check({e.name, ".flags"}, {13'd0, ras_full, ras_empty, ras_err}, {13'd0, e.flags});
    end
  endtask

  task automatic add(input logic [2:0] ps, input logic [W-1:0] pc_in, input logic [W-1:0] pc_on,
                     input logic [W-1:0] pc_off, input logic [2:0] f_on, input string name);
    vec_t v;
    v.ps = ps; v.pc_in = pc_in; v.name = name;
    v.pc    = RAS ? pc_on : pc_off;
    v.flags = RAS ? f_on : F_IDLE;
    tbl.push_back(v);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      PS = tbl[i].ps; PC_IN = tbl[i].pc_in;
      expect_next(tbl[i].pc, tbl[i].flags, tbl[i].name);
    end
    tbl.delete();
  endtask

  initial begin
    reset = 1'b1; PS = 3'b000; PC_IN = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset", RV);
    @(negedge clk);
    reset = 1'b0;

    // Basic modes, then call/return and relative call.
    add(3'b010, 16'h0010, 16'h0010, 16'h0010, 3'b010, "jmp_0x10");
    add(3'b001, 16'h0000, 16'h0011, 16'h0011, 3'b010, "inc");
    add(3'b010, 16'h0100, 16'h0100, 16'h0100, 3'b010, "jmp_0x100");
    add(3'b011, 16'hFFFC, 16'h00FC, 16'h00FC, 3'b010, "rel_m4");
    add(3'b000, 16'h1234, 16'h00FC, 16'h00FC, 3'b010, "stall");
    add(3'b111, 16'h4321, 16'h00FC, 16'h00FC, 3'b010, "reserved");
    add(3'b010, 16'h0020, 16'h0020, 16'h0020, 3'b010, "jmp_0x20");
    add(3'b100, 16'h0080, 16'h0080, 16'h0080, 3'b000, "call");
    add(3'b101, 16'h0000, 16'h0021, 16'h0081, 3'b010, "ret");
    add(3'b110, 16'h0010, 16'h0031, 16'h0091, 3'b000, "rcall");
    add(3'b101, 16'h0000, 16'h0022, 16'h0092, 3'b010, "rret");
    run_table();

    // Nine calls overflow an 8-deep stack; the oldest link is lost.
    add(3'b010, 16'h0000, 16'h0000, 16'h0000, 3'b010, "ovf_start");
    for (int i = 0; i < 9; i++) begin
      add(3'b100, 16'(i + 1), 16'(i + 1), 16'(i + 1),
          {(i >= 7) ? 1'b1 : 1'b0, 1'b0, (i == 8) ? 1'b1 : 1'b0}, $sformatf("ovf_call%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      add(3'b101, 16'h0000, 16'(9 - i), 16'(10 + i),
          {1'b0, (i == 7) ? 1'b1 : 1'b0, 1'b1}, $sformatf("ovf_ret%0d", i));
    end
    add(3'b101, 16'h0000, 16'h0003, 16'h0012, 3'b011, "udf_ret");
    add(3'b010, 16'h0040, 16'h0040, 16'h0040, 3'b011, "jmp_0x40");
    run_table();

    // Asynchronous reset between edges, held across an edge with a call pending.
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset", RV);
    PS = 3'b100; PC_IN = 16'h0080;
    @(posedge clk);
    #1;
    check_idle_outputs("reset_hold_call", RV);
    @(negedge clk);
    reset = 1'b0;
    expect_next(16'h0080, RAS ? 3'b000 : F_IDLE, "post_reset_call");

    add(3'b101, 16'h0000, RV + 16'd1, 16'h0081, 3'b010, "post_reset_ret");
    add(3'b010, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'b010, "jmp_max");
    add(3'b001, 16'h0000, 16'h0000, 16'h0000, 3'b010, "wrap_inc");
    add(3'b101, 16'h0000, 16'h0001, 16'h0001, 3'b011, "empty_ret");
    add(3'b000, 16'h0000, 16'h0001, 16'h0001, 3'b011, "err_sticky");
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
